pll_reset_sequencer: RTL

- Controls the core's clock-generation PLL from the always-running 74.25 MHz input clock.
- Issues the PLL reset pulse, synchronizes and qualifies the PLL lock output, and holds the core reset until lock has been stable for a set time.
- On lock loss or a restart request, re-runs the sequence.
- Sits between the platform reset and the PLL/core-reset tree; exports status for debug/host readback.

---
 rtl/pll_reset_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer on the always-running 74.25 MHz reference.
// Pulses the PLL reset, waits for a stable synchronized lock, then releases the core reset.

module pll_lock_sync (
    input  logic clk_74a,
    input  logic reset_n,
    input  logic pll_locked,
    output logic locked_s
);
    logic meta;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            meta     <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            meta     <= pll_locked;
            locked_s <= meta;
        end
    end
endmodule

module pll_reset_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int CNT_W        = 20
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       req_restart,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       pll_ready,
    output logic [7:0] relock_count,
    output logic       timeout_err,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       relock_nxt;
    logic             terr_nxt;
    logic             locked_s;

    pll_lock_sync u_sync (
        .clk_74a   (clk_74a),
        .reset_n   (reset_n),
        .pll_locked(pll_locked),
        .locked_s  (locked_s)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        relock_nxt = relock_count;
        terr_nxt   = timeout_err;
        // A restart outranks every other transition outside HOLD.
        if (req_restart && state != HOLD) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            terr_nxt  = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                        terr_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                        if (relock_count != 8'hFF) relock_nxt = relock_count + 8'd1;
                    end
                end
                default: begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state        <= HOLD;
            cnt          <= '0;
            relock_count <= 8'd0;
            timeout_err  <= 1'b0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            pll_ready    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            relock_count <= relock_nxt;
            timeout_err  <= terr_nxt;
            pll_rst      <= (state_nxt == HOLD);
            core_reset_n <= (state_nxt == RUN);
            pll_ready    <= (state_nxt == RUN);
        end
    end

    assign state_dbg = state;
endmodule
